// File: rtl/prelude_pkg.sv
// Shared definitions for the prelude core's register-IO peripherals.
package prelude_pkg;

  // UART transmitter frame phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Bit positions on the register-IO port.
  localparam int RIO_REQ_BIT  = 7;  // request toggle in rio_out
  localparam int RIO_ACK_BIT  = 7;  // acknowledge toggle in rio_in
  localparam int RIO_BUSY_BIT = 0;  // busy flag in rio_in

  // 8N1 frame: start + 8 data + stop.
  localparam int UART_FRAME_BITS = 10;

endpackage : prelude_pkg

// File: rtl/rio_uart_tx.sv
// rio_uart_tx: accepts 7-bit characters from the prelude core over a
// toggle handshake on rio_out[7] and sends each as an 8N1 UART frame.
// Acknowledge toggle and busy flag are returned on rio_in.
module rio_uart_tx
  import prelude_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rio_out,
  output logic [7:0] rio_in,
  output logic       tx
);

  // A bit period shorter than two clocks leaves no room for the counter.
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("rio_uart_tx: CLKS_PER_BIT must be at least 2");
  end

  localparam int              BAUD_W      = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  logic [7:0]        req_q;
  logic              ack_q;
  tx_state_t         state_q;
  logic [7:0]        shift_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bitcnt_q;
  logic              tx_q;
  logic              req_pending;

  // A request is outstanding while the core's toggle differs from our ack.
  assign req_pending = (req_q[RIO_REQ_BIT] != ack_q);

  // Register the core's port every cycle; all decisions use this copy.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= rio_out;
    end
  end

  // Frame sequencer: accept, start bit, 8 data bits LSB first, stop bit.
  // tx is updated alongside the state so the line is always a flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= 1'b0;
      state_q  <= IDLE;
      shift_q  <= '0;
      baud_q   <= '0;
      bitcnt_q <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (req_pending) begin
            shift_q <= {1'b0, req_q[6:0]};
            ack_q   <= req_q[RIO_REQ_BIT];
            baud_q  <= BAUD_RELOAD;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end

        START: begin
          if (baud_q == '0) begin
            baud_q   <= BAUD_RELOAD;
            bitcnt_q <= '0;
            tx_q     <= shift_q[0];
            state_q  <= DATA;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end

        DATA: begin
          if (baud_q == '0) begin
            baud_q  <= BAUD_RELOAD;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bitcnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q     <= shift_q[1];
              bitcnt_q <= bitcnt_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end

        STOP: begin
          tx_q <= 1'b1;
          if (baud_q == '0) begin
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end

        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Status word: ack toggle and busy, decoded from registered state only.
  // NOTE: every output of an always_comb gets a default first so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    rio_in               = '0;
    rio_in[RIO_ACK_BIT]  = ack_q;
    rio_in[RIO_BUSY_BIT] = (state_q != IDLE);
  end

  assign tx = tx_q;

endmodule : rio_uart_tx

// File: tb/tb_rio_uart_tx.sv
// Self-checking bench for rio_uart_tx: a 4-clock-per-bit instance for the
// directed latency/reset/payload cases and a 2-clock-per-bit instance for
// a streamed handshake run. A reference UART monitor per instance pops the
// expected byte queue as frames arrive.
module tb_rio_uart_tx;

  logic       clk = 1'b0;
  logic       rst4_n = 1'b0;
  logic       rst2_n = 1'b0;
  logic [7:0] rio4_out = 8'h00;
  logic [7:0] rio2_out = 8'h00;
  logic [7:0] rio4_in, rio2_in;
  logic       tx4, tx2;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp4[$];
  logic [7:0] exp2[$];
  int         rx_cnt4 = 0;
  int         rx_cnt2 = 0;

  always #5 clk = ~clk;

  rio_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk    (clk),
    .rst_n  (rst4_n),
    .rio_out(rio4_out),
    .rio_in (rio4_in),
    .tx     (tx4)
  );

  rio_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk    (clk),
    .rst_n  (rst2_n),
    .rio_out(rio2_out),
    .rio_in (rio2_in),
    .tx     (tx2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic line_of(input int sel);
    return (sel == 2) ? tx2 : tx4;
  endfunction

  function automatic logic rst_of(input int sel);
    return (sel == 2) ? rst2_n : rst4_n;
  endfunction

  // Reference UART receiver: samples every clock of a frame, requires each
  // bit to be held for n cycles, then compares the byte with the queue head.
  task automatic rx_mon(input int sel, input int n);
    logic       prev;
    logic       cur;
    logic       aborted;
    logic       hold_ok;
    logic [9:0] bits;
    logic [7:0] exp;
    logic       samp [0:159];
    prev = 1'b1;
    forever begin
      @(negedge clk);
      cur = line_of(sel);
      if (!rst_of(sel)) begin
        prev = 1'b1;
      end else if (prev && !cur) begin
        aborted = 1'b0;
        samp[0] = cur;
        for (int k = 1; k < prelude_pkg::UART_FRAME_BITS * n; k++) begin
          @(negedge clk);
          if (!rst_of(sel)) begin
            aborted = 1'b1;
            break;
          end
          samp[k] = line_of(sel);
        end
        if (!aborted) begin
          hold_ok = 1'b1;
          for (int b = 0; b < prelude_pkg::UART_FRAME_BITS; b++) begin
            bits[b] = samp[b * n];
            for (int j = 1; j < n; j++) begin
              if (samp[b * n + j] !== samp[b * n]) hold_ok = 1'b0;
            end
          end
          check($sformatf("rx%0d_hold", sel), 32'(hold_ok), 32'd1);
          check($sformatf("rx%0d_stop", sel), 32'(bits[9]), 32'd1);
          if (sel == 2) begin
            rx_cnt2++;
            if (exp2.size() == 0) check("rx2_extra", 32'd1, 32'd0);
            else begin
              exp = exp2.pop_front();
              check("rx2_data", 32'(bits[8:1]), 32'(exp));
            end
          end else begin
            rx_cnt4++;
            if (exp4.size() == 0) check("rx4_extra", 32'd1, 32'd0);
            else begin
              exp = exp4.pop_front();
              check("rx4_data", 32'(bits[8:1]), 32'(exp));
            end
          end
        end
        prev = 1'b1;
      end else begin
        prev = cur;
      end
    end
  endtask

  initial rx_mon(4, 4);
  initial rx_mon(2, 2);

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       tog;
    logic [7:0] ch;
    int         cnt;

    // Reset state and quiet line.
    repeat (3) @(negedge clk);
    check("rst_tx_low", 32'(tx4), 32'd1);
    check("rst_rio_low", 32'(rio4_in), 32'h00);
    #2 rst4_n = 1'b1; rst2_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_tx", 32'(tx4), 32'd1);
      check("idle_rio", 32'(rio4_in), 32'h00);
    end

    // 'A' with toggle 1: two-edge latency, then queue 0x42 right after ack.
    rio4_out = 8'hC1;
    exp4.push_back(8'h41);
    @(negedge clk);
    check("lat_k_tx", 32'(tx4), 32'd1);
    check("lat_k_rio", 32'(rio4_in), 32'h00);
    @(negedge clk);
    check("fall_tx", 32'(tx4), 32'd0);
    check("ack1_rio", 32'(rio4_in), 32'h81);
    rio4_out = 8'h42;
    exp4.push_back(8'h42);
    repeat (39) @(negedge clk);
    check("busy_39", 32'(rio4_in[0]), 32'd1);
    @(negedge clk);
    check("gap_rio", 32'(rio4_in), 32'h80);
    check("gap_tx", 32'(tx4), 32'd1);
    @(negedge clk);
    check("ack2_tx", 32'(tx4), 32'd0);
    check("ack2_rio", 32'(rio4_in), 32'h01);
    repeat (39) @(negedge clk);
    check("busy2_39", 32'(rio4_in[0]), 32'd1);
    @(negedge clk);
    check("done2_rio", 32'(rio4_in), 32'h00);

    // 'A' again, aborted by reset during its data bits.
    repeat (5) @(negedge clk);
    rio4_out = 8'hC1;
    exp4.push_back(8'h41);
    repeat (2) @(negedge clk);
    check("fall3_tx", 32'(tx4), 32'd0);
    repeat (14) @(negedge clk);
    #2 rst4_n = 1'b0;
    #1;
    check("rst_mid_tx", 32'(tx4), 32'd1);
    check("rst_mid_rio", 32'(rio4_in), 32'h00);
    repeat (2) @(negedge clk);
    #2 rst4_n = 1'b1;
    @(negedge clk);
    check("rel_k_tx", 32'(tx4), 32'd1);
    @(negedge clk);
    check("reack_tx", 32'(tx4), 32'd0);
    check("reack_rio", 32'(rio4_in), 32'h81);

    // Payload change mid-frame without toggling must not disturb anything.
    repeat (20) @(negedge clk);
    rio4_out = 8'hFF;
    repeat (19) @(negedge clk);
    check("busy3_39", 32'(rio4_in[0]), 32'd1);
    @(negedge clk);
    check("done3_rio", 32'(rio4_in), 32'h80);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("quiet_tx", 32'(tx4), 32'd1);
      check("quiet_rio", 32'(rio4_in), 32'h80);
    end
    check("rx4_count", 32'(rx_cnt4), 32'd3);
    check("rx4_left", 32'(exp4.size()), 32'd0);

    // Streamed handshake on the 2-clock instance.
    tog = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ch = 8'($urandom_range(0, 127));
      tog = ~tog;
      rio2_out = {tog, ch[6:0]};
      exp2.push_back({1'b0, ch[6:0]});
      cnt = 0;
      while (rio2_in[7] !== tog && cnt < 200) begin
        @(negedge clk);
        cnt++;
      end
      check("hs_ack", 32'(rio2_in[7]), 32'(tog));
    end
    cnt = 0;
    while ((rx_cnt2 < 16 || rio2_in[0] !== 1'b0) && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    repeat (5) @(negedge clk);
    check("rx2_count", 32'(rx_cnt2), 32'd16);
    check("rx2_left", 32'(exp2.size()), 32'd0);
    check("rx2_idle_tx", 32'(tx2), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rio_uart_tx
